// File: rtl/video_vblank_write_scheduler.sv
// video_vblank_write_scheduler: queues CPU video-register writes and replays them onto the
// video bus only during vertical blanking (or immediately in imm_mode), bounded per window.
module video_vblank_write_scheduler #(
    parameter int FIFO_AW   = 4,
    parameter int MAX_BURST = 8,
    parameter int ADDR_W    = 21
) (
    input  logic              clk_sys,
    input  logic              reset_sys_n,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic              imm_mode,
    input  logic              flush,
    input  logic              ovf_clr,
    input  logic              frame_start,
    input  logic              frame_end,
    output logic              video_cs,
    output logic              video_wr,
    output logic [ADDR_W-1:0] video_addr,
    output logic [31:0]       video_wr_data,
    output logic [FIFO_AW:0]  level,
    output logic              busy,
    output logic              ovf,
    output logic              late
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] BURST = (FIFO_AW + 1)'(MAX_BURST);
    localparam logic [FIFO_AW:0] ONE   = (FIFO_AW + 1)'(1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [1:0]         rst_sync_q, rst_sync_d;
    logic               rst_n_int;
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, budget_q, budget_d, occ;
    logic [ADDR_W+31:0] mem_q [DEPTH];
    logic [ADDR_W+31:0] head;
    logic               full, empty, start, cut, pop, push, ovf_set, late_set;
    logic               video_cs_q, video_cs_d, ovf_q, ovf_d, late_q, late_d;
    logic [ADDR_W-1:0]  video_addr_q, video_addr_d;
    logic [31:0]        video_data_q, video_data_d;

    assign rst_n_int = rst_sync_q[1];

    // Queue status, drain arbitration and next-state computation
    always_comb begin
        rst_sync_d   = {rst_sync_q[0], 1'b1};
        occ          = wr_ptr_q - rd_ptr_q;
        empty        = wr_ptr_q == rd_ptr_q;
        full         = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        head         = mem_q[rd_ptr_q[FIFO_AW-1:0]];
        start        = (state_q == IDLE) && !empty && !flush && (imm_mode || (frame_end && !frame_start));
        cut          = (state_q == DRAIN) && !flush && !imm_mode && frame_start;
        pop          = (state_q == DRAIN) && !flush && !cut && !empty;
        push         = req_wr && !flush && (!full || pop);
        ovf_set      = req_wr && !flush && full && !pop;
        late_set     = cut && (budget_q != '0);
        state_d      = start ? DRAIN : (pop && budget_q != ONE) ? DRAIN : IDLE;
        budget_d     = start ? ((occ < BURST) ? occ : BURST) : (state_d == DRAIN) ? budget_q - ONE : '0;
        wr_ptr_d     = push ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d     = flush ? wr_ptr_q : pop ? rd_ptr_q + ONE : rd_ptr_q;
        ovf_d        = ovf_set || (ovf_q && !ovf_clr);
        late_d       = late_set || (late_q && !ovf_clr);
        video_cs_d   = pop;
        video_addr_d = pop ? head[ADDR_W+31:32] : video_addr_q;
        video_data_d = pop ? head[31:0] : video_data_q;
    end

    // Reset synchroniser: asserts asynchronously, releases on the clock
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) rst_sync_q <= '0;
        else rst_sync_q <= rst_sync_d;
    end

    // Queue storage; pointers alone define which entries are valid
    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {req_addr, req_data};
    end

    // Control state, sticky flags and registered video bus outputs
    always_ff @(posedge clk_sys or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            budget_q     <= '0;
            ovf_q        <= 1'b0;
            late_q       <= 1'b0;
            video_cs_q   <= 1'b0;
            video_addr_q <= '0;
            video_data_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            budget_q     <= budget_d;
            ovf_q        <= ovf_d;
            late_q       <= late_d;
            video_cs_q   <= video_cs_d;
            video_addr_q <= video_addr_d;
            video_data_q <= video_data_d;
        end
    end

    assign video_cs      = video_cs_q;
    assign video_wr      = video_cs_q;
    assign video_addr    = video_addr_q;
    assign video_wr_data = video_data_q;
    assign level         = wr_ptr_q - rd_ptr_q;
    assign busy          = state_q == DRAIN;
    assign ovf           = ovf_q;
    assign late          = late_q;
endmodule

// File: tb/tb_video_vblank_write_scheduler.sv
// tb_video_vblank_write_scheduler: queue-level reference model compared every cycle, plus directed literal checks
`timescale 1ns/1ps
module tb_video_vblank_write_scheduler;
    localparam int MB    = 8;
    localparam int DEPTH = 16;

    logic        clk_sys = 1'b0;
    logic        reset_sys_n = 1'b0;
    logic        req_wr = 1'b0, imm_mode = 1'b0, flush = 1'b0, ovf_clr = 1'b0;
    logic        frame_start = 1'b0, frame_end = 1'b0;
    logic [20:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        video_cs, video_wr, busy, ovf, late;
    logic [20:0] video_addr;
    logic [31:0] video_wr_data;
    logic [4:0]  level;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    typedef struct { int c; logic [20:0] a; logic [31:0] d; } wr_t;
    wr_t         log_q[$];
    logic [52:0] mq[$];
    bit          m_drain = 0, m_cs = 0, m_ovf = 0, m_late = 0;
    int          m_budget = 0;
    logic [20:0] m_addr = '0;
    logic [31:0] m_data = '0;

    video_vblank_write_scheduler #(.FIFO_AW(4), .MAX_BURST(MB), .ADDR_W(21)) dut (
        .clk_sys(clk_sys), .reset_sys_n(reset_sys_n), .req_wr(req_wr), .req_addr(req_addr),
        .req_data(req_data), .imm_mode(imm_mode), .flush(flush), .ovf_clr(ovf_clr),
        .frame_start(frame_start), .frame_end(frame_end), .video_cs(video_cs), .video_wr(video_wr),
        .video_addr(video_addr), .video_wr_data(video_wr_data), .level(level), .busy(busy),
        .ovf(ovf), .late(late)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a plain queue, a window budget and the spec's replay rules
    task automatic model_step();
        bit          ovf_s = 0, late_s = 0;
        logic [52:0] e;
        m_cs = 0;
        if (flush) begin
            mq.delete();
            m_drain = 0;
            m_budget = 0;
        end else begin
            if (m_drain) begin
                if (frame_start && !imm_mode) begin
                    late_s = m_budget > 0;
                    m_drain = 0;
                    m_budget = 0;
                end else if (mq.size() > 0) begin
                    e = mq.pop_front();
                    {m_addr, m_data} = e;
                    m_cs = 1;
                    m_budget--;
                    m_drain = m_budget > 0;
                end else m_drain = 0;
            end else if (mq.size() > 0 && (imm_mode || (frame_end && !frame_start))) begin
                m_drain = 1;
                m_budget = mq.size() < MB ? mq.size() : MB;
            end
            if (req_wr) begin
                if (mq.size() < DEPTH) mq.push_back({req_addr, req_data});
                else ovf_s = 1;
            end
        end
        m_ovf = ovf_s || (m_ovf && !ovf_clr);
        m_late = late_s || (m_late && !ovf_clr);
    endtask

    initial forever begin
        @(posedge clk_sys or negedge reset_sys_n);
        if (!reset_sys_n) begin
            mq.delete();
            m_drain = 0; m_cs = 0; m_ovf = 0; m_late = 0; m_budget = 0; m_addr = '0; m_data = '0;
        end else model_step();
    end

    initial forever begin
        @(posedge clk_sys);
        cyc++;
    end

    // Every-cycle comparison against the model, plus a log of observed bus writes
    initial forever begin
        @(negedge clk_sys);
        chk("video_cs", video_cs, m_cs);
        chk("video_wr", video_wr, m_cs);
        chk("video_addr", video_addr, m_addr);
        chk("video_wr_data", video_wr_data, m_data);
        chk("level", level, mq.size());
        chk("busy", busy, m_drain);
        chk("ovf", ovf, m_ovf);
        chk("late", late, m_late);
        if (video_cs) log_q.push_back('{cyc, video_addr, video_wr_data});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk_sys);
            req_wr = 0; frame_end = 0; frame_start = 0; flush = 0; ovf_clr = 0;
        end
    endtask

    task automatic push(logic [20:0] a, logic [31:0] d);
        req_wr = 1; req_addr = a; req_data = d;
        tick();
    endtask

    task automatic pulse_fe();
        frame_end = 1;
        tick();
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin tick(); k++; end
        chk("drain_done_in_time", k < 40, 1);
        tick(2);
    endtask

    initial begin
        int t, m, k;
        tick(3);
        chk("rst_cs", video_cs, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        reset_sys_n = 1;
        tick(4);

        // Blanking replay with exact cycle timing
        push(21'h1000, 32'hA); push(21'h1004, 32'hB); push(21'h1008, 32'hC);
        tick();
        m = log_q.size(); t = cyc;
        frame_end = 1; tick(); tick(3);
        chk("replay_level_T4", level, 0);
        chk("replay_busy_T4", busy, 0);
        tick(2);
        chk("replay_count", log_q.size() - m, 3);
        for (int i = 0; i < 3; i++) begin
            chk("replay_cycle", log_q[m+i].c, t + 2 + i);
            chk("replay_addr", log_q[m+i].a, 21'h1000 + 21'(4 * i));
            chk("replay_data", log_q[m+i].d, 32'hA + 32'(i));
        end

        // Burst limit: 12 queued, 8 then 4
        m = log_q.size();
        for (int i = 0; i < 12; i++) push(21'(32'h2000 + 4 * i), 32'h100 + 32'(i));
        pulse_fe(); wait_idle();
        chk("burst_first_count", log_q.size() - m, 8);
        chk("burst_level_left", level, 4);
        pulse_fe(); wait_idle();
        chk("burst_total", log_q.size() - m, 12);
        for (int i = 0; i < 12; i++) chk("burst_order", log_q[m+i].a, 21'(32'h2000 + 4 * i));

        // Overflow: 17th write dropped
        m = log_q.size();
        for (int i = 0; i < 17; i++) push(21'(32'h3000 + 4 * i), 32'h300 + 32'(i));
        chk("ovf_level", level, 16);
        chk("ovf_set", ovf, 1);
        ovf_clr = 1; tick();
        chk("ovf_cleared", ovf, 0);
        pulse_fe(); wait_idle(); pulse_fe(); wait_idle();
        chk("ovf_replay_count", log_q.size() - m, 16);
        for (int i = 0; i < 16; i++) chk("ovf_replay_data", log_q[m+i].d, 32'h300 + 32'(i));

        // Early frame_start cuts the window after 3 writes
        m = log_q.size();
        for (int i = 0; i < 8; i++) push(21'(32'h4000 + 4 * i), 32'h400 + 32'(i));
        frame_end = 1; tick(); tick(3);
        frame_start = 1; tick(); tick(2);
        chk("late_count", log_q.size() - m, 3);
        chk("late_flag", late, 1);
        chk("late_level", level, 5);
        ovf_clr = 1; tick();
        chk("late_cleared", late, 0);
        pulse_fe(); wait_idle();
        chk("late_total", log_q.size() - m, 8);
        for (int i = 3; i < 8; i++) chk("late_resume_addr", log_q[m+i].a, 21'(32'h4000 + 4 * i));

        // Flush mid-drain with a simultaneous (discarded) write
        m = log_q.size();
        for (int i = 0; i < 6; i++) push(21'(32'h5000 + 4 * i), 32'h500 + 32'(i));
        frame_end = 1; tick(); tick();
        flush = 1; req_wr = 1; req_addr = 21'h5FFF; req_data = 32'hDEAD; tick();
        chk("flush_level", level, 0);
        chk("flush_busy", busy, 0);
        chk("flush_no_ovf", ovf, 0);
        tick(4);
        chk("flush_writes", log_q.size() - m, 1);
        chk("flush_first_addr", log_q[m].a, 21'h5000);

        // Full queue: push on a pop cycle is accepted
        for (int i = 0; i < 16; i++) push(21'(32'h6000 + 4 * i), 32'h600 + 32'(i));
        chk("full_level", level, 16);
        frame_end = 1; tick();
        for (int i = 0; i < 3; i++) push(21'(32'h6100 + 4 * i), 32'h610 + 32'(i));
        chk("pushpop_level", level, 16);
        chk("pushpop_no_ovf", ovf, 0);
        wait_idle();
        chk("pushpop_after_drain", level, 11);
        flush = 1; tick();
        chk("flush2_level", level, 0);

        // Immediate mode drains without blanking pulses
        imm_mode = 1;
        m = log_q.size();
        for (int i = 0; i < 10; i++) push(21'(32'h7000 + 4 * i), 32'h700 + 32'(i));
        k = 0;
        while ((level != 0 || busy) && k < 60) begin tick(); k++; end
        chk("imm_done_in_time", k < 60, 1);
        tick(2);
        imm_mode = 0;
        chk("imm_count", log_q.size() - m, 10);
        for (int i = 0; i < 10; i++) chk("imm_order", log_q[m+i].d, 32'h700 + 32'(i));

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 5; i++) push(21'(32'h8000 + 4 * i), 32'h800 + 32'(i));
        frame_end = 1; tick(); tick(2);
        #2 reset_sys_n = 0;
        #1;
        chk("rstmid_cs", video_cs, 0);
        chk("rstmid_level", level, 0);
        chk("rstmid_busy", busy, 0);
        tick(2);
        reset_sys_n = 1;
        tick(4);
        m = log_q.size();
        push(21'h9000, 32'h9);
        tick(3);
        chk("rstmid_quiet", log_q.size() - m, 0);
        pulse_fe(); wait_idle();
        chk("rstmid_replay_count", log_q.size() - m, 1);
        chk("rstmid_replay_addr", log_q[m].a, 21'h9000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
